// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_stage_elastic_pkg: shared defaults and state encoding for the elastic pipeline stage.
package pipe_stage_elastic_pkg;
   localparam logic [15:0] NOP_IR_DEF    = 16'hF000;
   localparam logic [7:0]  CTRL_SAFE_DEF = 8'h00;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;
endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: one-cycle elastic pipeline register with 2-entry skid, flush-to-NOP
// and a saturating stall counter.
module pipe_stage_elastic
   import pipe_stage_elastic_pkg::*;
#(
   parameter int                IR_W      = 16,
   parameter int                CTRL_W    = 8,
   parameter int                DATA_W    = 64,
   parameter logic [IR_W-1:0]   NOP_IR    = NOP_IR_DEF,
   parameter logic [CTRL_W-1:0] CTRL_SAFE = CTRL_SAFE_DEF,
   parameter int                CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [IR_W-1:0]   in_ir_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [IR_W-1:0]   out_ir_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   input  logic              stall_clr_i
);
   state_e              state_q, state_d;
   logic                in_ready_q;
   logic [IR_W-1:0]     ir_q, ir_d, sk_ir_q, sk_ir_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d, sk_ctrl_q, sk_ctrl_d;
   logic [DATA_W-1:0]   data_q, data_d, sk_data_q, sk_data_d;
   logic                in_fire, out_fire;
   assign in_fire  = in_valid_i && in_ready_q;
   assign out_fire = out_valid_o && out_ready_i;
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      sk_ir_d   = sk_ir_q;
      sk_ctrl_d = sk_ctrl_q;
      sk_data_d = sk_data_q;
      case (state_q)
         ST_EMPTY: if (in_fire) begin
            state_d = ST_ONE;
            ir_d    = in_ir_i;
            ctrl_d  = in_ctrl_i;
            data_d  = in_data_i;
         end
         ST_ONE: if (in_fire && out_fire) begin
            ir_d   = in_ir_i;
            ctrl_d = in_ctrl_i;
            data_d = in_data_i;
         end else if (in_fire) begin
            state_d   = ST_TWO;
            sk_ir_d   = in_ir_i;
            sk_ctrl_d = in_ctrl_i;
            sk_data_d = in_data_i;
         end else if (out_fire) state_d = ST_EMPTY;
         ST_TWO: if (out_fire) begin
            state_d = ST_ONE;
            ir_d    = sk_ir_q;
            ctrl_d  = sk_ctrl_q;
            data_d  = sk_data_q;
         end
         default: state_d = ST_EMPTY;
      endcase
      // flush wins over any transfer, including an accept in the same cycle
      if (flush_i) begin
         state_d = ST_EMPTY;
         ir_d    = NOP_IR;
         ctrl_d  = CTRL_SAFE;
         data_d  = '0;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         ir_q       <= NOP_IR;
         ctrl_q     <= CTRL_SAFE;
         data_q     <= '0;
         sk_ir_q    <= NOP_IR;
         sk_ctrl_q  <= CTRL_SAFE;
         sk_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= state_d != ST_TWO;
         ir_q       <= ir_d;
         ctrl_q     <= ctrl_d;
         data_q     <= data_d;
         sk_ir_q    <= sk_ir_d;
         sk_ctrl_q  <= sk_ctrl_d;
         sk_data_q  <= sk_data_d;
      end
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = state_q != ST_EMPTY;
   assign out_ir_o    = out_valid_o ? ir_q : NOP_IR;
   assign out_ctrl_o  = out_valid_o ? ctrl_q : CTRL_SAFE;
   assign out_data_o  = data_q;
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (out_valid_o && !out_ready_i),
      .clr_i (stall_clr_i),
      .cnt_o (stall_cnt_o)
   );
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_pipe_stage_elastic;
   typedef struct packed {
      logic [15:0] ir;
      logic [7:0]  ctrl;
      logic [63:0] data;
   } ent_t;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
   logic [15:0] in_ir, out_ir;
   logic [7:0]  in_ctrl, out_ctrl;
   logic [63:0] in_data, out_data;
   logic [3:0]  stall_cnt;
   ent_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   pipe_stage_elastic #(.CNT_W(4)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_ir_i    (in_ir),
      .in_ctrl_i  (in_ctrl),
      .in_data_i  (in_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_ir_o   (out_ir),
      .out_ctrl_o (out_ctrl),
      .out_data_o (out_data),
      .stall_cnt_o(stall_cnt),
      .stall_clr_i(stall_clr)
   );
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h required %h", n, a, e);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic ent_t mk(input logic [15:0] ir, input logic [7:0] c, input logic [63:0] d);
      ent_t e;
      e.ir   = ir;
      e.ctrl = c;
      e.data = d;
      return e;
   endfunction
   task automatic send(input ent_t e);
      in_valid = 1'b1;
      in_ir    = e.ir;
      in_ctrl  = e.ctrl;
      in_data  = e.data;
      for (int k = 0; k < 20 && !in_ready; k++) tick();
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=%b required 1 for ir %h", in_ready, e.ir);
         in_valid = 1'b0;
         return;
      end
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
   endtask
   task automatic chk_idle(input string n);
      chk({n, "_valid"}, out_valid, 0);
      chk({n, "_ir"}, out_ir, 16'hF000);
      chk({n, "_ctrl"}, out_ctrl, 8'h00);
      chk({n, "_data"}, out_data, 0);
      chk({n, "_in_ready"}, in_ready, 1);
   endtask
   initial begin
      fork
         forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_out: got ir %h, required no output", out_ir);
               end else begin
                  ent_t e;
                  e = sb.pop_front();
                  chk("mon_ir", out_ir, e.ir);
                  chk("mon_ctrl", out_ctrl, e.ctrl);
                  chk("mon_data", out_data, e.data);
               end
            end
         end
      join_none
      // 1. reset with random inputs
      rst_n = 1'b0;
      repeat (3) begin
         flush     = 1'($urandom);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         stall_clr = 1'($urandom);
         in_ir     = 16'($urandom);
         in_ctrl   = 8'($urandom);
         in_data   = {$urandom, $urandom};
         tick();
      end
      chk_idle("reset");
      chk("reset_stall", stall_cnt, 0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      stall_clr = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      tick();
      // 2. streaming, one per cycle with one-cycle latency
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         chk("stream_in_ready", in_ready, 1);
         send(mk(16'h1000 + 16'(i), 8'h10 + 8'(i), 64'hD000_0000_0000_0000 + 64'(i)));
         chk("stream_latency_ir", out_ir, 16'h1000 + 16'(i));
      end
      tick();
      chk("stream_drained", out_valid, 0);
      // 3. back-pressure into the skid
      out_ready = 1'b0;
      send(mk(16'h2000, 8'hA1, 64'hAAAA_0000_0000_0001));
      send(mk(16'h2001, 8'hB2, 64'hBBBB_0000_0000_0002));
      in_valid = 1'b1;
      in_ir    = 16'h2002;
      in_ctrl  = 8'hC3;
      in_data  = 64'hCCCC_0000_0000_0003;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_head_ir", out_ir, 16'h2000);
      tick();
      tick();
      chk("bp_head_hold", out_ir, 16'h2000);
      chk("bp_stall", stall_cnt, 3);
      out_ready = 1'b1;
      send(mk(16'h2002, 8'hC3, 64'hCCCC_0000_0000_0003));
      tick();
      chk("bp_stall_after", stall_cnt, 3);
      chk("bp_drained", sb.size(), 0);
      // 4. flush while TWO with an offered entry
      out_ready = 1'b0;
      send(mk(16'h3000, 8'hD4, 64'h1111_2222_3333_4444));
      send(mk(16'h3001, 8'hE5, 64'h5555_6666_7777_8888));
      chk("flush_pre_full", in_ready, 0);
      in_valid = 1'b1;
      in_ir    = 16'h3002;
      in_ctrl  = 8'hF6;
      in_data  = 64'h9999_AAAA_BBBB_CCCC;
      flush    = 1'b1;
      sb.delete();
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk_idle("flush");
      out_ready = 1'b1;
      repeat (3) tick();
      chk("flush_no_emit", out_valid, 0);
      // 5. stall counter saturation and clear priority
      out_ready = 1'b0;
      send(mk(16'h4000, 8'h44, 64'h4444_4444_4444_4444));
      repeat (20) tick();
      chk("sat_stall", stall_cnt, 15);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      chk("sat_clr", stall_cnt, 0);
      tick();
      chk("sat_resume", stall_cnt, 1);
      out_ready = 1'b1;
      tick();
      chk("sat_drained", sb.size(), 0);
      // 6. asynchronous reset between edges while TWO
      out_ready = 1'b0;
      send(mk(16'h5000, 8'h55, 64'h5));
      send(mk(16'h5001, 8'h56, 64'h6));
      chk("areset_pre_ir", out_ir, 16'h5000);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("areset");
      chk("areset_stall", stall_cnt, 0);
      sb.delete();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(mk(16'h6000, 8'h66, 64'h6666_0000_0000_6666));
      chk("restart_ir", out_ir, 16'h6000);
      repeat (3) tick();
      chk("final_drained", sb.size(), 0);
      chk("final_idle", out_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
